// File: rtl/ram_seq_pkg.sv
// Opcodes, ALU function codes, FSM states and control-word layout shared by the
// ram_datapath sequencer and its decoder.
package ram_seq_pkg;

   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] XZR = 5'd31;

   // 11-bit R / D / BR opcodes
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_EOR  = 11'b11001010000;
   localparam logic [10:0] OP_ADDS = 11'b10101011000;
   localparam logic [10:0] OP_SUBS = 11'b11101011000;
   localparam logic [10:0] OP_BR   = 11'b11010110000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;

   // 10-bit I-form opcodes
   localparam logic [9:0] OP_ADDI = 10'b1001000100;
   localparam logic [9:0] OP_SUBI = 10'b1101000100;

   // FS[4:2] function, FS[1] invert B, FS[0] invert A
   localparam logic [4:0] FS_AND = 5'b00000;
   localparam logic [4:0] FS_ORR = 5'b00100;
   localparam logic [4:0] FS_ADD = 5'b01000;
   localparam logic [4:0] FS_EOR = 5'b01100;
   localparam logic [4:0] FS_SUB = 5'b01010;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM1, S_MEM2} state_t;

   typedef struct packed {
      logic              w;
      logic              en_alu;
      logic              en_b;
      logic              en_addr;
      logic              k_sel;
      logic              pc_sel;
      logic              c0;
      logic              cs;
      logic              we;
      logic              oe;
      logic [ADDR_W-1:0] sa;
      logic [ADDR_W-1:0] sb;
      logic [ADDR_W-1:0] da;
      logic [4:0]        fs;
   } ctrl_t;

   // Quiescent control word: nothing enabled, all register ports parked on XZR.
   function automatic ctrl_t ctrl_idle();
      ctrl_t c;
      c    = '0;
      c.sa = XZR;
      c.sb = XZR;
      c.da = XZR;
      return c;
   endfunction

endpackage

// File: rtl/ram_seq_decode.sv
// Combinational LEGv8 decoder: instruction word -> ram_datapath control word.
// ADDS/SUBS decode only when SEQ_FLAGS_EN is defined.
module ram_seq_decode
   import ram_seq_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [31:0]       instr,
   output ctrl_t             ctrl,
   output logic [DATA_W-1:0] k,
   output logic              is_mem,
   output logic              illegal,
   output logic              set_flags
);

   logic [10:0]       op11;
   logic [9:0]        op10;
   logic [ADDR_W-1:0] rd, rn, rm;
   logic              r_op, i_op;

   assign op11 = instr[31:21];
   assign op10 = instr[31:22];
   assign rd   = instr[4:0];
   assign rn   = instr[9:5];
   assign rm   = instr[20:16];

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      ctrl      = ctrl_idle();
      k         = '0;
      is_mem    = 1'b0;
      illegal   = 1'b0;
      set_flags = 1'b0;
      r_op      = 1'b0;
      i_op      = 1'b0;

      case (op11)
         OP_ADD: begin r_op = 1'b1; ctrl.fs = FS_ADD; end
         OP_SUB: begin r_op = 1'b1; ctrl.fs = FS_SUB; ctrl.c0 = 1'b1; end
         OP_AND: begin r_op = 1'b1; ctrl.fs = FS_AND; end
         OP_ORR: begin r_op = 1'b1; ctrl.fs = FS_ORR; end
         OP_EOR: begin r_op = 1'b1; ctrl.fs = FS_EOR; end
`ifdef SEQ_FLAGS_EN
         OP_ADDS: begin r_op = 1'b1; ctrl.fs = FS_ADD; set_flags = 1'b1; end
         OP_SUBS: begin r_op = 1'b1; ctrl.fs = FS_SUB; ctrl.c0 = 1'b1; set_flags = 1'b1; end
`endif
         OP_BR: begin
            ctrl.sa     = rn;
            ctrl.pc_sel = 1'b1;
         end
         OP_LDUR: begin
            is_mem  = 1'b1;
            ctrl.oe = 1'b1;
            ctrl.da = rd;
         end
         OP_STUR: begin
            is_mem    = 1'b1;
            ctrl.we   = 1'b1;
            ctrl.en_b = 1'b1;
            ctrl.sb   = rd;
         end
         default: begin
            if (op10 == OP_ADDI || op10 == OP_SUBI) begin
               i_op    = 1'b1;
               ctrl.fs = (op10 == OP_SUBI) ? FS_SUB : FS_ADD;
               ctrl.c0 = (op10 == OP_SUBI);
            end else begin
               illegal = 1'b1;
            end
         end
      endcase

      if (r_op) begin
         ctrl.sa     = rn;
         ctrl.sb     = rm;
         ctrl.da     = rd;
         ctrl.en_alu = 1'b1;
         ctrl.w      = (rd != XZR);
      end

      if (i_op) begin
         ctrl.sa     = rn;
         ctrl.da     = rd;
         k           = DATA_W'(instr[21:10]);
         ctrl.k_sel  = 1'b1;
         ctrl.en_alu = 1'b1;
         ctrl.w      = (rd != XZR);
      end

      // Load write-back is raised by the sequencer in MEM2, so W stays 0 here.
      if (is_mem) begin
         ctrl.sa      = rn;
         k            = DATA_W'($signed(instr[20:12]));
         ctrl.k_sel   = 1'b1;
         ctrl.fs      = FS_ADD;
         ctrl.en_addr = 1'b1;
         ctrl.cs      = 1'b1;
      end
   end

endmodule

// File: rtl/ram_datapath_sequencer.sv
// Multi-cycle LEGv8 sequencer driving the ram_datapath control word.
// Optional SEQ_FLAGS_EN: ADDS/SUBS latch Status into flags.
module ram_datapath_sequencer
   import ram_seq_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [31:0]       instr,
   output logic              instr_ready,
   output logic              illegal,
   input  logic [3:0]        Status,
   output logic [3:0]        flags,
   output logic              W,
   output logic              EN_ALU,
   output logic              EN_B,
   output logic              EN_ADDR,
   output logic              K_SEL,
   output logic              PC_SEL,
   output logic              C0,
   output logic              CS,
   output logic              WE,
   output logic              OE,
   output logic [REG_AW-1:0] SA,
   output logic [REG_AW-1:0] SB,
   output logic [REG_AW-1:0] DA,
   output logic [4:0]        FS,
   output logic [DATA_W-1:0] K
);

   state_t            state_q, state_d;
   ctrl_t             ctrl_q, ctrl_d, dec_ctrl;
   logic [DATA_W-1:0] k_q, k_d, dec_k;
   logic              dec_mem, dec_illegal, dec_setf;
   logic              illegal_q, illegal_d, setf_q, setf_d;
   logic              accept;

   ram_seq_decode #(.DATA_W(DATA_W)) u_decode (
      .instr     (instr),
      .ctrl      (dec_ctrl),
      .k         (dec_k),
      .is_mem    (dec_mem),
      .illegal   (dec_illegal),
      .set_flags (dec_setf)
   );

   assign instr_ready = ~rst & (state_q != S_MEM1);
   assign accept      = instr_valid & instr_ready;

   always_comb begin
      state_d   = S_IDLE;
      ctrl_d    = ctrl_idle();
      k_d       = '0;
      illegal_d = 1'b0;
      setf_d    = 1'b0;
      if (state_q == S_MEM1) begin
         state_d  = S_MEM2;
         ctrl_d   = ctrl_q;
         k_d      = k_q;
         ctrl_d.w = ctrl_q.oe & (ctrl_q.da != XZR);
      end else if (accept) begin
         state_d   = dec_mem ? S_MEM1 : S_EXEC;
         ctrl_d    = dec_ctrl;
         k_d       = dec_k;
         illegal_d = dec_illegal;
         setf_d    = dec_setf;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: the whole control word is reset, so an aborted LDUR/STUR leaves no W or WE behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q    <= ctrl_idle();
         k_q       <= '0;
         illegal_q <= 1'b0;
         setf_q    <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         k_q       <= k_d;
         illegal_q <= illegal_d;
         setf_q    <= setf_d;
      end
   end

`ifdef SEQ_FLAGS_EN
   logic [3:0] flags_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              flags_q <= '0;
      else if (state_q == S_EXEC && setf_q) flags_q <= Status;
   end
   assign flags = flags_q;
`else
   logic unused_flag_inputs;
   assign unused_flag_inputs = ^{Status, setf_q};
   assign flags = 4'b0000;
`endif

   assign illegal = illegal_q;
   assign W       = ctrl_q.w;
   assign EN_ALU  = ctrl_q.en_alu;
   assign EN_B    = ctrl_q.en_b;
   assign EN_ADDR = ctrl_q.en_addr;
   assign K_SEL   = ctrl_q.k_sel;
   assign PC_SEL  = ctrl_q.pc_sel;
   assign C0      = ctrl_q.c0;
   assign CS      = ctrl_q.cs;
   assign WE      = ctrl_q.we;
   assign OE      = ctrl_q.oe;
   assign SA      = ctrl_q.sa;
   assign SB      = ctrl_q.sb;
   assign DA      = ctrl_q.da;
   assign FS      = ctrl_q.fs;
   assign K       = k_q;

endmodule
